// File: rtl/nbit_down_timer_if.sv
// nbit_down_timer_if: load/count request and status bundle of the N-bit down timer.
// The master drives the load value and the active-low LOAD/COUNT strobes.
// The slave (the timer) returns the count and the ZERO, TC and BUSY flags.
interface nbit_down_timer_if #(
    parameter int N = 4
) ();
    logic         LOAD;
    logic         COUNT;
    logic [N-1:0] in;
    logic [N-1:0] y;
    logic         ZERO;
    logic         TC;
    logic         BUSY;

    modport master (
        output LOAD,
        output COUNT,
        output in,
        input  y,
        input  ZERO,
        input  TC,
        input  BUSY
    );

    modport slave (
        input  LOAD,
        input  COUNT,
        input  in,
        output y,
        output ZERO,
        output TC,
        output BUSY
    );
endinterface

// File: rtl/nbit_down_timer.sv
// nbit_down_timer: loadable N-bit down-counter with a terminal-count pulse.
// Edge priority is CLEAR low > LOAD low > COUNT low > hold.
// The IDLE/RUN/DONE FSM gates decrementing, so the counter never wraps below zero.
// Optional build macro AUTO_RELOAD_EN: on terminal count, reload from the last
// loaded value and keep running instead of stopping in DONE.
module nbit_down_timer #(
    parameter int N = 4
) (
    input  logic                CLK,
    input  logic                CLEAR,
    nbit_down_timer_if.slave    bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]   state_q, state_d;
    logic [N-1:0] y_q, y_d;
    logic [N-1:0] r_q, r_d;
    logic         tc_q, tc_d;

    // Next-state: load, decrement while running, terminal count handling
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        r_d     = r_q;
        tc_d    = 1'b0;
        if (!bus.LOAD) begin
            y_d     = bus.in;
            r_d     = bus.in;
            state_d = (bus.in != '0) ? ST_RUN : ST_DONE;
        end else if (!bus.COUNT && state_q == ST_RUN) begin
            if (y_q > ONE) begin
                y_d = y_q - ONE;
            end else begin
                tc_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                // r_q is non-zero here: a zero load never enters RUN
                y_d  = r_q;
`else
                y_d     = '0;
                state_d = ST_DONE;
`endif
            end
        end
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge CLK) begin
        if (!CLEAR) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            r_q     <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            r_q     <= r_d;
            tc_q    <= tc_d;
        end
    end

    // Outputs: registered count and TC, combinational ZERO and BUSY
    always_comb begin
        bus.y    = y_q;
        bus.TC   = tc_q;
        bus.ZERO = (y_q == '0);
        bus.BUSY = (state_q == ST_RUN);
    end
endmodule
